mdu_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer with architectural HI/LO registers for the five-stage MIPS pipeline. It sits beside the single-cycle ALU in the EX stage. It accepts one mult/div/mthi/mtlo command per start pulse and holds `busy` for a fixed operation latency. It commits results to HI/LO at the end of that latency. The hazard unit stalls on `busy | start` for any MD-class instruction.

---
 rtl/md_pkg.sv | 29 ++
 rtl/md_compute.sv | 56 +++++
 rtl/mdu_sequencer.sv | 115 +++++++++++
 tb/tb_mdu_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: command encodings,
// default latencies and the sequencer state type.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        MD_IDLE,
        MD_RUN
    } md_state_e;

    // mult/multu/div/divu are the only commands that occupy the unit
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath producing {hi, lo} for one command.
// Division works on magnitudes so 0x80000000 / -1 wraps instead of trapping.
module md_compute
    import md_pkg::*;
(
    input  logic [2:0]  mdOp,
    input  logic [31:0] Src1,
    input  logic [31:0] Src2,
    output logic [63:0] result,
    output logic        divZero
);

    logic        is_signed;
    logic        is_div;
    logic        a_neg;
    logic        b_neg;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        is_signed = (mdOp == MD_MULT) || (mdOp == MD_DIV);
        is_div    = md_is_div(mdOp);

        // low 64 bits of the extended product are exact for both signednesses
        a_ext   = is_signed ? {{32{Src1[31]}}, Src1} : {32'd0, Src1};
        b_ext   = is_signed ? {{32{Src2[31]}}, Src2} : {32'd0, Src2};
        product = a_ext * b_ext;

        a_neg   = is_signed & Src1[31];
        b_neg   = is_signed & Src2[31];
        a_mag   = a_neg ? -Src1 : Src1;
        b_mag   = b_neg ? -Src2 : Src2;
        divZero = is_div && (Src2 == 32'd0);
        b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag   = a_mag / b_safe;
        r_mag   = a_mag % b_safe;
        quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem     = a_neg ? -r_mag : r_mag;

        result = 64'd0;
        if (is_div) begin
            result = {rem, quot};
        end else if (md_is_arith(mdOp)) begin
            result = product;
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the architectural HI/LO pair.
// Results are computed at issue, held pending, and committed when the latency expires.
module mdu_sequencer
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  mdOp,
    input  logic [31:0] Src1,
    input  logic [31:0] Src2,
    input  logic        readHi,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdOut
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] p_hi_q, p_hi_d;
    logic [31:0] p_lo_q, p_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        div_zero_q, div_zero_d;
    logic        busy_q, busy_d;

    logic [63:0] calc_result;
    logic        calc_div_zero;

    md_compute u_compute (
        .mdOp    (mdOp),
        .Src1    (Src1),
        .Src2    (Src2),
        .result  (calc_result),
        .divZero (calc_div_zero)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        p_hi_d     = p_hi_q;
        p_lo_d     = p_lo_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;

        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    if (md_is_arith(mdOp)) begin
                        state_d    = MD_RUN;
                        cnt_d      = md_is_div(mdOp) ? DIV_LOAD : MULT_LOAD;
                        p_hi_d     = calc_result[63:32];
                        p_lo_d     = calc_result[31:0];
                        div_zero_d = calc_div_zero;
                    end else if (mdOp == MD_MTHI) begin
                        hi_d = Src1;
                    end else if (mdOp == MD_MTLO) begin
                        lo_d = Src1;
                    end
                end
            end
            MD_RUN: begin
                // start is deliberately not looked at here: commands in flight are dropped
                if (cnt_q == 4'd0) begin
                    state_d = MD_IDLE;
                    if (!div_zero_q) begin
                        hi_d = p_hi_q;
                        lo_d = p_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = MD_IDLE;
        endcase

        busy_d = (state_d == MD_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MD_IDLE;
            cnt_q      <= 4'd0;
            p_hi_q     <= 32'd0;
            p_lo_q     <= 32'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            p_hi_q     <= p_hi_d;
            p_lo_q     <= p_lo_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
            busy_q     <= busy_d;
        end
    end

    assign busy  = busy_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign mdOut = readHi ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: a driver issues directed and random commands
// and queues expected HI/LO from a 64-bit arithmetic model; a monitor checks them.
module tb_mdu_sequencer;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  mdOp;
    logic [31:0] Src1;
    logic [31:0] Src2;
    logic        readHi;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdOut;

    mdu_sequencer #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mdOp   (mdOp),
        .Src1   (Src1),
        .Src2   (Src2),
        .readHi (readHi),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .mdOut  (mdOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_arith;
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
        logic [2:0]  op;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    bit          rh_rand  = 1'b1;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int          run_len   = 0;
    bit          busy_prev = 1'b0;
    logic [31:0] ref_hi    = 32'd0;
    logic [31:0] ref_lo    = 32'd0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            run_len   = 0;
            busy_prev = 1'b0;
            ref_hi    = 32'd0;
            ref_lo    = 32'd0;
        end else begin
            if (sb_q.size() > 0 && !sb_q[0].is_arith) begin
                e = sb_q.pop_front();
                check32("mt_hi", hi, e.hi);
                check32("mt_lo", lo, e.lo);
                check1("mt_busy", busy, 1'b0);
                ref_hi = e.hi;
                ref_lo = e.lo;
                $display("txn op=%0d hi=%h lo=%h busy=%b", e.op, hi, lo, busy);
            end
            if (busy) begin
                run_len++;
                check32("hold_hi", hi, ref_hi);
                check32("hold_lo", lo, ref_lo);
            end else if (busy_prev) begin
                n_checks++;
                if (sb_q.size() == 0 || !sb_q[0].is_arith) begin
                    n_fails++;
                    $display("FAIL unexpected_busy_end: got busy run of %0d, expected none", run_len);
                end else begin
                    e = sb_q.pop_front();
                    check32("busy_len", 32'(run_len), 32'(e.len));
                    check32("res_hi", hi, e.hi);
                    check32("res_lo", lo, e.lo);
                    ref_hi = e.hi;
                    ref_lo = e.lo;
                    $display("txn op=%0d hi=%h lo=%h busy_cycles=%0d", e.op, hi, lo, run_len);
                end
                run_len = 0;
            end
            check32("mdOut", mdOut, readHi ? ref_hi : ref_lo);
            busy_prev = busy;
        end
    end

    initial begin
        readHi = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rh_rand) readHi = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit drop_mtlo);
        exp_t            e;
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        @(posedge clk);
        #1;
        start = 1'b1;
        mdOp  = op;
        Src1  = a;
        Src2  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        mdOp  = 3'($urandom);
        Src1  = $urandom;
        Src2  = $urandom;

        e.op       = op;
        e.is_arith = (op <= 3'd3);
        e.len      = (op == 3'd2 || op == 3'd3) ? DIV_N : MULT_N;
        case (op)
            3'd0: begin
                sa = longint'($signed(a)); sb = longint'($signed(b)); sp = sa * sb;
                model_hi = sp[63:32]; model_lo = sp[31:0];
            end
            3'd1: begin
                ua = longint'(a); ub = longint'(b); up = ua * ub;
                model_hi = up[63:32]; model_lo = up[31:0];
            end
            3'd2: if (b != 32'd0) begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                sp = sa / sb; model_lo = sp[31:0];
                sp = sa % sb; model_hi = sp[31:0];
            end
            3'd3: if (b != 32'd0) begin
                ua = longint'(a); ub = longint'(b);
                up = ua / ub; model_lo = up[31:0];
                up = ua % ub; model_hi = up[31:0];
            end
            3'd4: model_hi = a;
            3'd5: model_lo = a;
            default: ;
        endcase
        e.hi = model_hi;
        e.lo = model_lo;
        sb_q.push_back(e);

        if (e.is_arith) begin
            if (drop_mtlo && e.len >= 3) begin
                @(posedge clk);
                #1;
                start = 1'b1;
                mdOp  = 3'd5;
                Src1  = $urandom;
                @(posedge clk);
                #1;
                start = 1'b0;
                repeat (e.len - 3) @(posedge clk);
            end else begin
                repeat (e.len - 1) @(posedge clk);
            end
        end
    endtask

    // lands in the first cycle after busy has fallen
    task automatic expect_after(input string nm, input logic [31:0] eh, input logic [31:0] el);
        repeat (2) @(negedge clk);
        check32({nm, "_hi"}, hi, eh);
        check32({nm, "_lo"}, lo, el);
        check1({nm, "_busy"}, busy, 1'b0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mdOp  = 3'd0;
        Src1  = 32'd0;
        Src2  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check1("reset_busy", busy, 1'b0);
        check32("reset_hi", hi, 32'd0);
        check32("reset_lo", lo, 32'd0);

        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        expect_after("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        expect_after("multu", 32'h0000_0002, 32'hFFFF_FFFA);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        expect_after("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        expect_after("div_ovf", 32'h0000_0000, 32'h8000_0000);

        issue(3'd4, 32'h0000_1234, 32'd0, 1'b0);
        issue(3'd5, 32'h0000_5678, 32'd0, 1'b0);
        issue(3'd3, 32'hDEAD_BEEF, 32'd0, 1'b0);
        expect_after("divu_zero", 32'h0000_1234, 32'h0000_5678);

        rh_rand = 1'b0;
        issue(3'd4, 32'hAAAA_5555, 32'd0, 1'b0);
        readHi = 1'b1;
        @(negedge clk);
        check32("mthi_hi", hi, 32'hAAAA_5555);
        check1("mthi_busy", busy, 1'b0);
        check32("mthi_mdOut", mdOut, 32'hAAAA_5555);
        rh_rand = 1'b1;

        issue(3'd0, 32'd7, 32'd9, 1'b1);
        expect_after("mult_drop", 32'd0, 32'd63);

        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), ($urandom_range(0, 7) == 0));
        end

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        expect_after("pre_abort", 32'hFFFF_FFFE, 32'h0000_0001);
        issue(3'd4, 32'h0F0F_0F0F, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b1;
        mdOp  = 3'd2;
        Src1  = 32'd100;
        Src2  = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        model_hi = 32'd0;
        model_lo = 32'd0;
        check1("abort_busy", busy, 1'b0);
        check32("abort_hi", hi, 32'd0);
        check32("abort_lo", lo, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (DIV_N + 2) @(negedge clk);
        check1("abort_stay_idle", busy, 1'b0);
        check32("abort_no_commit_lo", lo, 32'd0);

        issue(3'd3, 32'd100, 32'd7, 1'b0);
        expect_after("post_abort", 32'd2, 32'd14);

        for (int i = 0; i < 30 && sb_q.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fails++;
            $display("FAIL drain: %0d transactions outstanding, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
